// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game controller:
//   - BCD_W     : width of a two-digit BCD value {tens, ones}
//   - state_e   : game FSM encoding (IDLE=0 READY=1 RUN=2 HIT=3 OVER=4)
//   - bcd_inc() : two-digit BCD increment that saturates at 99
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int BCD_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_HIT   = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    // Ones digit 9 wraps to 0 and carries into tens; 99 stays 99.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        if (v == 8'h99)
            return v;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/jump_debounce.sv
// ---------------------------------------------------------------------------
// jump_debounce
// Cleans up the raw, asynchronous, active-low jump button.
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   jump_n  in  raw button, active-low, asynchronous to clk
//   press   out one-cycle pulse on the debounced 1->0 edge
// Latency from a jump_n fall to press: 2 (sync) + DEB_CYC (stability) + 1 (edge).
// ---------------------------------------------------------------------------
module jump_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic jump_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        press_d = deb_prev_q & ~deb_q;
        // Count consecutive synchronised samples that disagree with the
        // accepted level; any agreeing sample restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the released button level is 1, so the synchroniser and the
    // debounced level reset high to avoid a spurious press after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= jump_n;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
// Top-level game controller: game FSM, speed-scaled step divider, BCD score
// and high score.
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   jump_n     in   raw jump button, active-low, asynchronous
//   collide    in   collision level from the collide logic
//   start      out  1 in READY/RUN/HIT/OVER
//   pause      out  0 only in RUN
//   step       out  one-cycle game advance pulse (RUN only)
//   press      out  one-cycle debounced jump request
//   blink      out  toggles per tick in HIT, 1 in OVER, else 0
//   state      out  FSM state encoding
//   score_bcd  out  {tens,ones} BCD score
//   hi_bcd     out  {tens,ones} BCD high score
// ---------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int BASE_DIV    = 50000,
    parameter int DIV_DEC     = 4000,
    parameter int MIN_DIV     = 14000,
    parameter int COUNT_STEPS = 3,
    parameter int HIT_STEPS   = 4,
    parameter int DEB_CYC     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_n,
    input  logic             collide,
    output logic             start,
    output logic             pause,
    output logic             step,
    output logic             press,
    output logic             blink,
    output logic [2:0]       state,
    output logic [BCD_W-1:0] score_bcd,
    output logic [BCD_W-1:0] hi_bcd
);

    localparam int DIV_W   = $clog2(BASE_DIV + 1);
    localparam int CNT_MAX = (COUNT_STEPS > HIT_STEPS) ? COUNT_STEPS : HIT_STEPS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Step period for the level given by the score's tens digit.
    function automatic logic [DIV_W-1:0] level_div(input logic [BCD_W-1:0] s);
        int d;
        d = BASE_DIV - int'(s[7:4]) * DIV_DEC;
        if (d < MIN_DIV)
            d = MIN_DIV;
        return DIV_W'(d);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [BCD_W-1:0] score_q, score_d;
    logic [BCD_W-1:0] hi_q, hi_d;
    logic             blink_q, blink_d;
    logic             start_q, start_d;
    logic             pause_q, pause_d;
    logic             tick;

    jump_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_jump_debounce (
        .clk    (clk),
        .rst    (rst),
        .jump_n (jump_n),
        .press  (press)
    );

    assign tick = (div_cnt_q == cur_div_q - DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        score_d   = score_q;
        hi_d      = hi_q;
        blink_d   = 1'b0;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        cur_div_d = cur_div_q;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (press) begin
                    state_d = S_READY;
                    score_d = '0;
                    cnt_d   = CNT_W'(COUNT_STEPS);
                end
            end
            S_READY: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Collision outranks a coincident tick: the step is dropped.
                if (collide) begin
                    state_d = S_HIT;
                    cnt_d   = CNT_W'(HIT_STEPS);
                end else if (tick) begin
                    score_d = bcd_inc(score_q);
                end
            end
            S_HIT: begin
                if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = S_OVER;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Blink follows the state being entered so it is a clean register.
        if (state_d == S_HIT && state_q == S_HIT)
            blink_d = tick ? ~blink_q : blink_q;
        else if (state_d == S_OVER)
            blink_d = 1'b1;

        if (state_d == S_OVER && state_q != S_OVER && score_q > hi_q)
            hi_d = score_q;

        // A new count starts on every tick and every state change; the period
        // is reloaded only then, from the score that is about to be held, so a
        // fresh game always starts at the base rate.
        if (tick || state_d != state_q) begin
            div_cnt_d = '0;
            cur_div_d = level_div(score_d);
        end

        start_d = (state_d != S_IDLE);
        pause_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_cnt_q <= '0;
            cur_div_q <= DIV_W'(BASE_DIV);
            score_q   <= '0;
            hi_q      <= '0;
            blink_q   <= 1'b0;
            start_q   <= 1'b0;
            pause_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_cnt_q <= div_cnt_d;
            cur_div_q <= cur_div_d;
            score_q   <= score_d;
            hi_q      <= hi_d;
            blink_q   <= blink_d;
            start_q   <= start_d;
            pause_q   <= pause_d;
        end
    end

    // Step must honour a collide that arrives in the tick cycle itself.
    assign step      = (state_q == S_RUN) && tick && !collide;
    assign start     = start_q;
    assign pause     = pause_q;
    assign blink     = blink_q;
    assign state     = state_q;
    assign score_bcd = score_q;
    assign hi_bcd    = hi_q;

endmodule
